// File: rtl/opera_arb_pkg.sv
// Shared encodings for the operand-A arbiter: FSM states, mux select values
// and the owner-selection rule used from both IDLE and TURN.
package opera_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2,
        TURN    = 2'd3
    } arb_state_e;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    // A CPU that was cut off by a capped DMA burst goes first; otherwise DMA wins ties.
    function automatic arb_state_e pick_owner(input logic req_cpu,
                                              input logic req_dma,
                                              input logic cpu_owed);
        if (req_cpu && cpu_owed) begin
            return GNT_CPU;
        end else if (req_dma) begin
            return GNT_DMA;
        end else if (req_cpu) begin
            return GNT_CPU;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/opera_burst_cnt.sv
// Saturating DMA burst-length counter; at_max_o flags the last cycle a DMA
// burst may keep the path while the CPU is waiting.
module opera_burst_cnt #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: next-state logic assigns its default before any branch so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/opera_arbiter.sv
// Operand-A path arbiter between the CPU register file (D0A) and the DMA engine (Otro):
// one-cycle turnaround on owner change, DMA bursts capped while the CPU is waiting.
module opera_arbiter
    import opera_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_dma,
    input  logic dma_last,
    output logic gnt_cpu,
    output logic gnt_dma,
    output logic sel_OperaA,
    output logic busy,
    output logic preempt
);

    arb_state_e state_q, state_d;
    logic       cpu_owed_q, cpu_owed_d;
    logic       sel_q, sel_d;
    logic       preempt_d;
    logic       gnt_cpu_q, gnt_dma_q, busy_q, preempt_q;
    logic       at_max;

    opera_burst_cnt #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != GNT_DMA),
        .inc_i    (state_q == GNT_DMA),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d    = state_q;
        cpu_owed_d = cpu_owed_q;
        sel_d      = sel_q;
        preempt_d  = 1'b0;

        case (state_q)
            IDLE, TURN: state_d = pick_owner(req_cpu, req_dma, cpu_owed_q);
            GNT_CPU: begin
                if (!req_cpu) state_d = TURN;
            end
            GNT_DMA: begin
                if (req_cpu && at_max) begin
                    state_d    = TURN;
                    preempt_d  = 1'b1;
                    cpu_owed_d = 1'b1;
                end else if (!req_dma || dma_last) begin
                    state_d = TURN;
                end
            end
            default: state_d = IDLE;
        endcase

        // The select only moves when a new owner takes the path; TURN and IDLE hold it.
        if (state_d == GNT_CPU && state_q != GNT_CPU) begin
            sel_d      = SEL_CPU;
            cpu_owed_d = 1'b0;
        end else if (state_d == GNT_DMA && state_q != GNT_DMA) begin
            sel_d = SEL_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cpu_owed_q <= 1'b0;
            sel_q      <= SEL_CPU;
            gnt_cpu_q  <= 1'b0;
            gnt_dma_q  <= 1'b0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_owed_q <= cpu_owed_d;
            sel_q      <= sel_d;
            gnt_cpu_q  <= (state_d == GNT_CPU);
            gnt_dma_q  <= (state_d == GNT_DMA);
            busy_q     <= (state_d != IDLE);
            preempt_q  <= preempt_d;
        end
    end

    // preempt rides with the turnaround cycle that follows the cut DMA burst.
    assign gnt_cpu    = gnt_cpu_q;
    assign gnt_dma    = gnt_dma_q;
    assign sel_OperaA = sel_q;
    assign busy       = busy_q;
    assign preempt    = preempt_q;

endmodule

// File: tb/tb_opera_arbiter.sv
// Scoreboard bench for opera_arbiter: stimulus queues the expected output vector
// for each cycle, a monitor pops and compares after every rising edge.
module tb_opera_arbiter;

    logic clk;
    logic reset;
    logic req_cpu;
    logic req_dma;
    logic dma_last;
    logic gnt_cpu;
    logic gnt_dma;
    logic sel_OperaA;
    logic busy;
    logic preempt;

    int total = 0;
    int bad   = 0;

    // Expected vector packing: {gnt_cpu, gnt_dma, sel_OperaA, busy, preempt}
    typedef struct {
        string      name;
        logic [4:0] v;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [4:0] O_ZERO    = 5'b00000;
    localparam logic [4:0] O_DMA     = 5'b01110;
    localparam logic [4:0] O_CPU     = 5'b10010;
    localparam logic [4:0] O_PREEMPT = 5'b00111;
    localparam logic [4:0] O_TURN_S1 = 5'b00110;
    localparam logic [4:0] O_TURN_S0 = 5'b00010;
    localparam logic [4:0] O_IDLE_S1 = 5'b00100;

    opera_arbiter #(
        .MAX_BURST (16),
        .CNT_W     (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_cpu    (req_cpu),
        .req_dma    (req_dma),
        .dma_last   (dma_last),
        .gnt_cpu    (gnt_cpu),
        .gnt_dma    (gnt_dma),
        .sel_OperaA (sel_OperaA),
        .busy       (busy),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_excl: assert property (@(posedge clk) disable iff (reset) !(gnt_cpu && gnt_dma))
        else $error("FAIL grant_excl: gnt_cpu and gnt_dma both high");

    a_turn_sel: assert property (@(posedge clk) disable iff (reset)
                                 (busy && !gnt_cpu && !gnt_dma) |-> $stable(sel_OperaA))
        else $error("FAIL turn_sel: sel_OperaA changed during turnaround");

    task automatic check(input string name, input logic [4:0] actual, input logic [4:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %b expected %b ({gc,gd,sel,busy,pre}) at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string name, input logic rst, input logic rc, input logic rd,
                        input logic last, input logic [4:0] ev);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        req_cpu  = rc;
        req_dma  = rd;
        dma_last = last;
        e.name   = name;
        e.v      = ev;
        exp_q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, {gnt_cpu, gnt_dma, sel_OperaA, busy, preempt}, e.v);
        end
    end

    initial begin
        reset    = 1'b1;
        req_cpu  = 1'b1;
        req_dma  = 1'b1;
        dma_last = 1'b0;

        // Reset with both requests pending, then DMA wins and is capped at 16 cycles.
        repeat (3)  step("t1_reset", 1, 1, 1, 0, O_ZERO);
        repeat (16) step("t3_dma_burst", 0, 1, 1, 0, O_DMA);
        step("t3_preempt", 0, 1, 1, 0, O_PREEMPT);
        repeat (4)  step("t3_cpu_owed", 0, 1, 1, 0, O_CPU);
        step("t3_turn_cpu", 0, 0, 1, 0, O_TURN_S0);
        step("t3_dma_regrant", 0, 0, 1, 0, O_DMA);
        step("t3_turn_dma", 0, 0, 0, 0, O_TURN_S1);
        step("t3_idle", 0, 0, 0, 0, O_IDLE_S1);

        // CPU alone.
        repeat (4) step("t2_cpu", 0, 1, 0, 0, O_CPU);
        step("t2_turn", 0, 0, 0, 0, O_TURN_S0);
        step("t2_idle", 0, 0, 0, 0, O_ZERO);

        // dma_last without a DMA grant has no effect.
        repeat (2) step("last_no_gnt", 0, 0, 0, 1, O_ZERO);

        // DMA alone, uncapped.
        repeat (40) step("t4_dma_long", 0, 0, 1, 0, O_DMA);
        step("t4_turn", 0, 0, 0, 0, O_TURN_S1);
        step("t4_idle", 0, 0, 0, 0, O_IDLE_S1);

        // dma_last on the third owned cycle ends the burst; DMA re-granted after TURN.
        repeat (3) step("t5_dma", 0, 0, 1, 0, O_DMA);
        step("t5_last_turn", 0, 0, 1, 1, O_TURN_S1);
        step("t5_regrant", 0, 0, 1, 0, O_DMA);
        step("t5_turn", 0, 0, 0, 0, O_TURN_S1);
        step("t5_idle", 0, 0, 0, 0, O_IDLE_S1);

        // Reset during the 5th burst cycle; a full 16-cycle burst afterwards shows the count restarted.
        repeat (5)  step("t6_dma", 0, 0, 1, 0, O_DMA);
        step("t6_reset", 1, 1, 1, 0, O_ZERO);
        repeat (16) step("t6_dma_after", 0, 1, 1, 0, O_DMA);
        step("t6_preempt", 0, 1, 1, 0, O_PREEMPT);
        step("t6_cpu", 0, 1, 1, 0, O_CPU);
        step("t6_turn", 0, 0, 0, 0, O_TURN_S0);
        step("t6_idle", 0, 0, 0, 0, O_ZERO);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
